// File: rtl/w_writeback_grf_pkg.sv
// ---------------------------------------------------------------------------
// mips_defs : shared MIPS encodings and write-back definitions.
//   - opcode / funct / COP0 rs-field constants
//   - REG_RA (jal link register), RESET_PC (trace PC after reset)
//   - wb_src_e : where the W stage takes its write-back data from
// Used by wb_decode (and later the hazard unit) and the W-stage top.
// ---------------------------------------------------------------------------
package mips_defs;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW     = 5;

  // primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0c;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MTHI    = 6'h11;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MTLO    = 6'h13;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1a;
  localparam logic [5:0] F_DIVU    = 6'h1b;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_SLT     = 6'h2a;
  localparam logic [5:0] F_SLTU    = 6'h2b;

  // COP0 rs-field sub-ops (eret uses CP0_CO)
  localparam logic [4:0] CP0_MF = 5'h00;
  localparam logic [4:0] CP0_MT = 5'h04;
  localparam logic [4:0] CP0_CO = 5'h10;

  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;
  localparam logic [31:0]       RESET_PC = 32'h0000_3000;

  typedef enum logic [2:0] {
    WB_NONE = 3'd0,
    WB_ALU  = 3'd1,
    WB_DM   = 3'd2,
    WB_MD   = 3'd3,
    WB_PC8  = 3'd4
  } wb_src_e;

endpackage

// File: rtl/w_writeback_grf_if.sv
// ---------------------------------------------------------------------------
// w_writeback_grf_if : W-stage bundle, D-stage read ports, W write bus and
// commit trace of the write-back / register-file block.
//   slave  : the block's view (bundle + read addresses in, everything else out)
//   master : the pipeline's view
// ---------------------------------------------------------------------------
interface w_writeback_grf_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  // W-stage bundle
  logic [DATA_W-1:0] in_pc;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_alu_out;
  logic [DATA_W-1:0] in_dm_out;
  logic [DATA_W-1:0] in_md_out;
  // D-stage read ports
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  // W write bus (forwarding source)
  logic              w_we;
  logic [4:0]        w_addr;
  logic [DATA_W-1:0] w_data;
  // commit trace
  logic              commit_valid;
  logic [DATA_W-1:0] commit_pc;
  logic [4:0]        commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic [CNT_W-1:0]  retire_count;

  modport slave (
    input  in_pc, in_instr, in_alu_out, in_dm_out, in_md_out, rs_addr, rt_addr,
    output rs_data, rt_data, w_we, w_addr, w_data,
           commit_valid, commit_pc, commit_addr, commit_data, retire_count
  );

  modport master (
    output in_pc, in_instr, in_alu_out, in_dm_out, in_md_out, rs_addr, rt_addr,
    input  rs_data, rt_data, w_we, w_addr, w_data,
           commit_valid, commit_pc, commit_addr, commit_data, retire_count
  );
endinterface

// File: rtl/w_writeback_grf_wb_decode.sv
// ---------------------------------------------------------------------------
// wb_decode : combinational W-stage write-back decode.
//   i_instr    : instruction word (0 = bubble)
//   o_we_raw   : instruction writes a GPR (destination may still be $0)
//   o_dst      : destination register index
//   o_wb_src   : write-back data source
// Anything not decoded below is non-writing (stores, branches, jr,
// mult/div/mthi/mtlo, mtc0, eret, syscall, bubble).
// ---------------------------------------------------------------------------
module wb_decode
  import mips_defs::*;
(
  input  logic [31:0]       i_instr,
  output logic              o_we_raw,
  output logic [REG_AW-1:0] o_dst,
  output wb_src_e           o_wb_src
);
  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic              w_unused_shamt;

  assign w_op           = i_instr[31:26];
  assign w_rs           = i_instr[25:21];
  assign w_rt           = i_instr[20:16];
  assign w_rd           = i_instr[15:11];
  assign w_funct        = i_instr[5:0];
  assign w_unused_shamt = ^i_instr[10:6];

  always_comb begin
    o_we_raw = 1'b0;
    o_dst    = '0;
    o_wb_src = WB_NONE;
    case (w_op)
      OP_SPECIAL: begin
        case (w_funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLTU: begin
            o_we_raw = 1'b1;
            o_dst    = w_rd;
            o_wb_src = WB_ALU;
          end
          F_MFHI, F_MFLO: begin
            o_we_raw = 1'b1;
            o_dst    = w_rd;
            o_wb_src = WB_MD;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
        o_we_raw = 1'b1;
        o_dst    = w_rt;
        o_wb_src = WB_ALU;
      end
      OP_LB, OP_LH, OP_LW: begin
        o_we_raw = 1'b1;
        o_dst    = w_rt;
        o_wb_src = WB_DM;
      end
      OP_COP0: begin
        // only mfc0 writes; CP0 read data rides on the load-data path
        if (w_rs == CP0_MF) begin
          o_we_raw = 1'b1;
          o_dst    = w_rt;
          o_wb_src = WB_DM;
        end
      end
      OP_JAL: begin
        o_we_raw = 1'b1;
        o_dst    = REG_RA;
        o_wb_src = WB_PC8;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/w_writeback_grf.sv
// ---------------------------------------------------------------------------
// w_writeback_grf : W-stage write-back and general register file.
//   clk, reset : clock; synchronous active-high reset
//   bus        : w_writeback_grf_if.slave
//     in_*              W-stage bundle (pc, instr, alu/dm/md results)
//     rs/rt_addr/_data  D-stage read ports with same-cycle write-through
//     w_we/addr/data    combinational W write bus for E/M forwarding
//     commit_*          registered copy of last cycle's write bus + pc
//     retire_count      non-bubble instructions seen since reset
// ---------------------------------------------------------------------------
module w_writeback_grf
  import mips_defs::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  w_writeback_grf_if.slave  bus
);
  localparam int NUM_RD = 2;

  logic              w_we_raw;
  logic [REG_AW-1:0] w_dst;
  wb_src_e           w_src;
  logic [DATA_W-1:0] w_mux;
  logic              w_we;
  logic [REG_AW-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  logic [DATA_W-1:0] r_grf [REG_NUM];

  logic [NUM_RD-1:0][REG_AW-1:0] w_rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data;

  logic              r_commit_valid;
  logic [DATA_W-1:0] r_commit_pc;
  logic [REG_AW-1:0] r_commit_addr;
  logic [DATA_W-1:0] r_commit_data;
  logic [CNT_W-1:0]  r_retire_count;

  wb_decode u_dec (
    .i_instr  (bus.in_instr),
    .o_we_raw (w_we_raw),
    .o_dst    (w_dst),
    .o_wb_src (w_src)
  );

  always_comb begin
    w_mux = '0;
    case (w_src)
      WB_ALU:  w_mux = bus.in_alu_out;
      WB_DM:   w_mux = bus.in_dm_out;
      WB_MD:   w_mux = bus.in_md_out;
      WB_PC8:  w_mux = bus.in_pc + DATA_W'(8);
      default: w_mux = '0;
    endcase
  end

  // $0 writes are squashed here so every consumer of the bus sees a clean 0
  assign w_we   = w_we_raw && (w_dst != '0);
  assign w_addr = w_we ? w_dst : '0;
  assign w_data = w_we ? w_mux : '0;

  // w_we never targets index 0, so entry 0 stays at its reset value
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) r_grf[i] <= '0;
    end else if (w_we) begin
      r_grf[w_addr] <= w_data;
    end
  end

  // read ports: $0 forced to zero, then same-cycle W bypass, then array
  assign w_rd_addr = {bus.rt_addr, bus.rs_addr};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign w_rd_data[p] = (w_rd_addr[p] == '0)                ? '0     :
                          (w_we && (w_rd_addr[p] == w_addr)) ? w_data :
                                                               r_grf[w_rd_addr[p]];
  end

  assign bus.rs_data = w_rd_data[0];
  assign bus.rt_data = w_rd_data[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_commit_valid <= 1'b0;
      r_commit_pc    <= DATA_W'(RESET_PC);
      r_commit_addr  <= '0;
      r_commit_data  <= '0;
      r_retire_count <= '0;
    end else begin
      r_commit_valid <= w_we;
      r_commit_pc    <= bus.in_pc;
      r_commit_addr  <= w_addr;
      r_commit_data  <= w_data;
      // bubbles don't retire; non-writing instructions do
      if (bus.in_instr != '0) r_retire_count <= r_retire_count + CNT_W'(1);
    end
  end

  assign bus.w_we         = w_we;
  assign bus.w_addr       = w_addr;
  assign bus.w_data       = w_data;
  assign bus.commit_valid = r_commit_valid;
  assign bus.commit_pc    = r_commit_pc;
  assign bus.commit_addr  = r_commit_addr;
  assign bus.commit_data  = r_commit_data;
  assign bus.retire_count = r_retire_count;
endmodule

// File: doc/w_writeback_grf.md
Name: w_writeback_grf

Overview:
- Consumer end of the W pipeline register. Takes the latched W-stage bundle, decodes the instruction, selects write-back data and destination, and commits it into the 32x32 general register file.
- Serves the two D-stage read ports with write-through bypass.
- Exports the W write bus for forwarding to the E and M stages.
- Keeps a retire counter and a one-cycle commit strobe for the grading trace.

Parameters:
- DATA_W, 32, datapath width.
- REG_NUM, 32, number of architectural registers; index width is 5.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_pc  in  32  PC of the W instruction
- in_instr  in  32  W instruction word; 0 = bubble
- in_alu_out  in  32  ALU/immediate result
- in_dm_out  in  32  load data, already extended; also carries CP0 read data for mfc0
- in_md_out  in  32  HI/LO value for mfhi/mflo
- rs_addr  in  5  D-stage read port A index
- rt_addr  in  5  D-stage read port B index
- rs_data  out  32  port A data
- rt_data  out  32  port B data
- w_we  out  1  W write enable (combinational)
- w_addr  out  5  W destination index (combinational)
- w_data  out  32  W write data (combinational)
- commit_valid  out  1  registered: one commit occurred last cycle
- commit_pc  out  32  registered PC of that commit
- commit_addr  out  5  registered destination of that commit
- commit_data  out  32  registered data of that commit
- retire_count  out  CNT_W  instructions retired since reset

Behaviour:
- Decode classes. Any opcode/funct not listed is non-writing.
  - ALU R-type (add, sub, and, or, slt, sltu): destination rd = instr[15:11]; data in_alu_out.
  - Immediate (addi, andi, ori, lui): destination rt = instr[20:16]; data in_alu_out.
  - Load (lb, lh, lw): destination rt; data in_dm_out.
  - mfc0: destination rt; data in_dm_out.
  - mfhi/mflo: destination rd; data in_md_out.
  - jal: destination 31; data in_pc + 8, computed here modulo 2^32.
  - Non-writing: stores, branches, jr, mult/div/mthi/mtlo/mtc0, eret, syscall, and instr = 0.
- w_we is 1 only when the instruction writes and the destination is not 0. When w_we = 0, w_addr and w_data are driven to 0.
- Register file:
  - grf[w_addr] <= w_data on posedge clk when w_we and not reset.
  - grf[0] always reads 0 and is never written.
- Read ports (combinational):
  - rs_data = 0 if rs_addr == 0.
  - Otherwise rs_data = w_data if w_we and rs_addr == w_addr (same-cycle bypass).
  - Otherwise rs_data = grf[rs_addr]. rt_data is identical.
- Commit trace: the commit_* outputs register the w_* values each cycle. commit_valid = registered w_we. Latency is 1 cycle after the W cycle.
- Retire counter: increments by 1 per cycle when in_instr != 0, including non-writing instructions. Wraps at 2^CNT_W to 0.
- Reset (synchronous):
  - All registers 1..31 cleared to 0.
  - commit_valid = 0; commit_pc = 0x3000.
  - commit_addr = 0, commit_data = 0, retire_count = 0.
  - A write presented in the reset cycle is discarded.
- Both read ports may name the same register. A bypass hit applies to both.
- Combinational outputs are defined by the current inputs even during reset. Reads during reset return the pre-reset array contents, except index 0.

Decomposition:
- Shared package mips_defs:
  - opcode and funct localparams;
  - REG_RA = 31;
  - writeback-source enum WB_ALU, WB_DM, WB_MD, WB_PC8, WB_NONE;
  - RESET_PC = 0x3000.
- Sub-module wb_decode: combinational. Maps instr to (we_raw, dst, wb_src). Reused later by the hazard unit for W-stage Tnew/destination lookup.
- Top: data mux, GRF array, bypass, trace/counter registers.

Test Plan:
- Reset, then read all 32 indices -> every rs_data/rt_data is 0; retire_count = 0; commit_valid = 0; commit_pc = 0x3000.
- W holds ori $5,$0,0x1234 with alu_out = 0x1234, and rs_addr = 5 in the same cycle -> rs_data = 0x1234 via bypass. Next cycle: reg5 = 0x1234 from the array; commit_valid = 1, commit_addr = 5, commit_pc = in_pc.
- jal at pc 0x3010 -> w_addr = 31, w_data = 0x3018. Then lw $8 with dm_out = 0xDEADBEEF -> reg8 = 0xDEADBEEF. Then mflo $9 with md_out = 7 -> reg9 = 7.
- addu-class write to $0 (rd = 0, alu_out = 0xFFFF) -> w_we = 0; rs_addr = 0 reads 0; commit_valid = 0 next cycle.
- sw, beq, then bubble (instr = 0) -> no register changes. retire_count rises by 2, not 3.
- Assert reset in the same cycle as a write to $3 = 0xAA -> reg3 = 0 afterwards. Force retire_count to 0xFFFFFFFF (CNT_W = 32) then retire one instruction -> count = 0.
